// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned KeyCodeW = 4;
  localparam int unsigned NumRows  = 4;
  localparam int unsigned NumCols  = 4;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHeld,
    StRelease
  } state_e;

  // Lowest-indexed active-low row wins when several rows are pulled down together.
  function automatic logic [1:0] first_low_row(input logic [NumRows-1:0] rows);
    if (!rows[0]) begin
      first_low_row = 2'd0;
    end else if (!rows[1]) begin
      first_low_row = 2'd1;
    end else if (!rows[2]) begin
      first_low_row = 2'd2;
    end else begin
      first_low_row = 2'd3;
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, with a synchronous reset value.
module sync_2ff #(
  parameter int unsigned      Width    = 4,
  parameter logic [Width-1:0] ResetVal = '1
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] s1_q;
  logic [Width-1:0] s2_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      s1_q <= ResetVal;
      s2_q <= ResetVal;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column sweep, debounced press/release, key code and strobe.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_COUNT = 20,
  parameter int unsigned DIV_WIDTH      = 16
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [3:0]          row,
  output logic [3:0]          col,
  output logic [KeyCodeW-1:0] key_code,
  output logic                key_valid,
  output logic                key_held
);

  localparam int unsigned          CntW     = $clog2(DEBOUNCE_COUNT + 1) < 1 ? 1 :
                                              $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [DIV_WIDTH-1:0] DivLast  = DIV_WIDTH'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]      CntOne   = CntW'(1);
  localparam logic [CntW-1:0]      CntDone  = CntW'(DEBOUNCE_COUNT);
  localparam bit                   OneShot  = (DEBOUNCE_COUNT <= 1);

  logic [3:0]          row_sync;
  logic [DIV_WIDTH-1:0] div_q;
  logic                sample;
  state_e              state_q;
  logic [1:0]          col_idx_q;
  logic [3:0]          col_q;
  logic [CntW-1:0]     cnt_q;
  logic [CntW-1:0]     cnt_inc;
  logic [1:0]          cand_row_q;
  logic                cand_low;
  logic                any_low;
  logic [KeyCodeW-1:0] key_code_q;
  logic                key_valid_q;
  logic                key_held_q;

  sync_2ff #(
    .Width   (4),
    .ResetVal(4'hF)
  ) u_row_sync (
    .clk_i(clk),
    .clr_i(clr),
    .d_i  (row),
    .q_o  (row_sync)
  );

  assign sample   = (div_q == DivLast);
  assign cnt_inc  = cnt_q + CntOne;
  assign cand_low = ~row_sync[cand_row_q];
  assign any_low  = ~&row_sync;

  always_ff @(posedge clk) begin
    if (clr || sample) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StScan;
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      cnt_q       <= '0;
      cand_row_q  <= 2'd0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (sample) begin
        unique case (state_q)
          StScan: begin
            if (any_low) begin
              // Column stays frozen on the candidate until it is accepted or rejected.
              cand_row_q <= first_low_row(row_sync);
              cnt_q      <= CntOne;
              if (OneShot) begin
                key_code_q  <= {first_low_row(row_sync), col_idx_q};
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                state_q     <= StHeld;
              end else begin
                state_q <= StDebounce;
              end
            end else begin
              col_idx_q <= col_idx_q + 2'd1;
              col_q     <= {col_q[2:0], col_q[3]};
            end
          end
          StDebounce: begin
            if (!cand_low) begin
              cnt_q     <= '0;
              state_q   <= StScan;
              col_idx_q <= col_idx_q + 2'd1;
              col_q     <= {col_q[2:0], col_q[3]};
            end else if (cnt_inc == CntDone) begin
              cnt_q       <= '0;
              key_code_q  <= {cand_row_q, col_idx_q};
              key_valid_q <= 1'b1;
              key_held_q  <= 1'b1;
              state_q     <= StHeld;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          StHeld: begin
            // Other rows are ignored here; only the accepted key's row matters.
            if (!cand_low) begin
              if (OneShot) begin
                cnt_q      <= '0;
                key_held_q <= 1'b0;
                state_q    <= StScan;
                col_idx_q  <= col_idx_q + 2'd1;
                col_q      <= {col_q[2:0], col_q[3]};
              end else begin
                cnt_q   <= CntOne;
                state_q <= StRelease;
              end
            end
          end
          StRelease: begin
            if (cand_low) begin
              cnt_q   <= '0;
              state_q <= StHeld;
            end else if (cnt_inc == CntDone) begin
              cnt_q      <= '0;
              key_held_q <= 1'b0;
              state_q    <= StScan;
              col_idx_q  <= col_idx_q + 2'd1;
              col_q      <= {col_q[2:0], col_q[3]};
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: state_q <= StScan;
        endcase
      end
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
